ram_burst_reader: RTL and testbench

RAM_BURST_READER -- requirements
Module: ram_burst_reader

---
 rtl/ram_burst_reader_if.sv | 34 +++
 rtl/ram_burst_reader.sv | 133 +++++++++++++
 tb/tb_ram_burst_reader.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_burst_reader_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ram_burst_reader_if : burst control, RAM read port and output stream |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface ram_burst_reader_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              busy;
  logic              done;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (
    input  start, base_addr, length, ram_dout, m_ready,
    output busy, done, ram_en, ram_we, ram_addr, m_data, m_valid, m_last
  );

  modport slave (
    output start, base_addr, length, ram_dout, m_ready,
    input  busy, done, ram_en, ram_we, ram_addr, m_data, m_valid, m_last
  );
endinterface
`default_nettype wire

// File: rtl/ram_burst_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ram_burst_reader : streams a RAM address range out as a valid/ready |
// | burst through a 2-entry fall-through FIFO.  Rev 1.0                 |
// +--------------------------------------------------------------------+
module ram_burst_reader #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  ram_burst_reader_if.master bus_io
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] C_ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   C_LEN_ONE  = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic [ADDR_W:0]   beats_q, beats_d;
  logic              done_q, done_d;
  logic              inflight_q;
  logic [1:0]        count_q;
  logic              rd_ptr_q, wr_ptr_q;
  logic [DATA_W-1:0] fifo_q [2];

  logic              w_valid;
  logic [DATA_W-1:0] w_head;
  logic              w_pop;
  logic              w_issue;
  logic              w_store;
  logic              w_deq;

  // The word returning from the RAM counts as occupancy: with an empty FIFO
  // it is presented directly, which gives the 2-cycle start-to-valid latency.
  always_comb begin
    w_valid = (count_q != 2'd0) || inflight_q;
    w_head  = (count_q != 2'd0) ? fifo_q[rd_ptr_q] : bus_io.ram_dout;
    w_pop   = w_valid && bus_io.m_ready;
    w_deq   = w_pop && (count_q != 2'd0);
    w_store = inflight_q && !(w_pop && (count_q == 2'd0));
    w_issue = (state_q == S_READ) && (remain_q != '0) &&
              (({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, w_pop}));
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    beats_d  = beats_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // done_q high means a burst just finished; a start here is dropped
        if (bus_io.start && !done_q) begin
          if (bus_io.length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = S_READ;
            addr_d   = bus_io.base_addr;
            remain_d = bus_io.length;
            beats_d  = bus_io.length;
          end
        end
      end
      S_READ: begin
        if (w_issue) begin
          addr_d   = addr_q + C_ADDR_ONE;
          remain_d = remain_q - C_LEN_ONE;
          if (remain_q == C_LEN_ONE) state_d = S_DRAIN;
        end
        if (w_pop) beats_d = beats_q - C_LEN_ONE;
      end
      S_DRAIN: begin
        if (w_pop) begin
          beats_d = beats_q - C_LEN_ONE;
          if (beats_q == C_LEN_ONE) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      beats_q    <= '0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      beats_q    <= beats_d;
      done_q     <= done_d;
      inflight_q <= w_issue;
      count_q    <= count_q + {1'b0, w_store} - {1'b0, w_deq};
      if (w_deq) rd_ptr_q <= ~rd_ptr_q;
      if (w_store) begin
        fifo_q[wr_ptr_q] <= bus_io.ram_dout;
        wr_ptr_q         <= ~wr_ptr_q;
      end
    end
  end

  assign bus_io.busy     = (state_q != S_IDLE);
  assign bus_io.done     = done_q;
  assign bus_io.ram_en   = w_issue;
  assign bus_io.ram_we   = 1'b0;
  assign bus_io.ram_addr = addr_q;
  assign bus_io.m_valid  = w_valid;
  assign bus_io.m_data   = w_valid ? w_head : '0;
  assign bus_io.m_last   = w_valid && (beats_q == C_LEN_ONE);

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ram_burst_reader : directed bench with a behavioural 1-cycle RAM |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_ram_burst_reader;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   lc;
  logic [15:0] mem [2048];

  ram_burst_reader_if #(.ADDR_W(11), .DATA_W(16)) bus ();

  ram_burst_reader #(.ADDR_W(11), .DATA_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_en) bus.ram_dout <= mem[bus.ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one step after the edge that samples start.
  task automatic start_burst(input logic [10:0] base, input logic [11:0] len);
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.length    = len;
    tick();
    bus.start = 1'b0;
  endtask

  // mode 0: m_ready held high; mode 1: periodic stalls.
  // inj >= 0 raises a foreign start request at that cycle of the burst.
  task automatic run_burst(input logic [10:0] base, input int len, input int mode,
                           input int inj, output int last_cyc);
    int          n, issued, cyc, outst;
    logic        rdy, pv, pr, pl, ok;
    logic [15:0] pd;
    logic [10:0] ea;
    n = 0; issued = 0; cyc = 0; pv = 0; pr = 0; pl = 0; pd = '0;
    last_cyc = -1;
    while (n < len && cyc < 4 * len + 20) begin
      rdy = (mode == 0) ? 1'b1 : (((cyc * 5 + 3) % 7) < 4);
      bus.m_ready = rdy;
      bus.start   = (cyc == inj);
      if (cyc == inj) begin
        bus.base_addr = 11'h300;
        bus.length    = 12'd2;
      end
      #1;
      check("busy_run", {31'd0, bus.busy}, 32'd1);
      if (cyc == 0) begin
        check("lat_ram_en", {31'd0, bus.ram_en}, 32'd1);
        check("lat_valid0", {31'd0, bus.m_valid}, 32'd0);
      end
      if (cyc == 1) check("lat_valid1", {31'd0, bus.m_valid}, 32'd1);
      outst = issued - n;
      if (bus.ram_en) begin
        ea = base + 11'(issued);
        check("rd_addr", {21'd0, bus.ram_addr}, {21'd0, ea});
        ok = (outst - ((bus.m_valid && rdy) ? 1 : 0)) < 2;
        check("issue_rule", {31'd0, ok}, 32'd1);
        check("rd_count", {31'd0, issued < len}, 32'd1);
        issued++;
      end
      if (pv && !pr) begin
        check("stall_valid", {31'd0, bus.m_valid}, 32'd1);
        check("stall_data", {16'd0, bus.m_data}, {16'd0, pd});
        check("stall_last", {31'd0, bus.m_last}, {31'd0, pl});
      end
      if (bus.m_valid && rdy) begin
        ea = base + 11'(n);
        check("beat_data", {16'd0, bus.m_data}, {21'd0, ea});
        check("beat_last", {31'd0, bus.m_last}, {31'd0, n == len - 1});
        n++;
        if (n == len) last_cyc = cyc;
      end
      pv = bus.m_valid; pr = rdy; pd = bus.m_data; pl = bus.m_last;
      tick();
      cyc++;
    end
    bus.start   = 1'b0;
    bus.m_ready = 1'b0;
    #1;
    check("beat_count", n, len);
    check("done_pulse", {31'd0, bus.done}, 32'd1);
    check("busy_fall", {31'd0, bus.busy}, 32'd0);
    check("valid_after", {31'd0, bus.m_valid}, 32'd0);
    tick();
    check("done_clear", {31'd0, bus.done}, 32'd0);
    check("idle_after", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"},   {31'd0, bus.busy},     32'd0);
    check({tag, "_done"},   {31'd0, bus.done},     32'd0);
    check({tag, "_ram_en"}, {31'd0, bus.ram_en},   32'd0);
    check({tag, "_ram_we"}, {31'd0, bus.ram_we},   32'd0);
    check({tag, "_addr"},   {21'd0, bus.ram_addr}, 32'd0);
    check({tag, "_valid"},  {31'd0, bus.m_valid},  32'd0);
    check({tag, "_last"},   {31'd0, bus.m_last},   32'd0);
    check({tag, "_data"},   {16'd0, bus.m_data},   32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = 16'(i);
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.length    = '0;
    bus.m_ready   = 1'b0;
    bus.ram_dout  = '0;

    // Reset state
    tick();
    check_zero_outputs("rst");
    tick();
    rst_n = 1'b1;

    // Basic burst, full throughput: last beat in cycle 4 after the start edge
    start_burst(11'h010, 12'd4);
    run_burst(11'h010, 4, 0, -1, lc);
    check("throughput_last_cyc", lc, 4);

    // Zero length, with start held into the done cycle
    bus.start     = 1'b1;
    bus.base_addr = 11'h055;
    bus.length    = 12'd0;
    tick();
    check("zl_done", {31'd0, bus.done}, 32'd1);
    check("zl_busy", {31'd0, bus.busy}, 32'd0);
    check("zl_ram_en", {31'd0, bus.ram_en}, 32'd0);
    check("zl_valid", {31'd0, bus.m_valid}, 32'd0);
    bus.base_addr = 11'h100;
    bus.length    = 12'd5;
    tick();
    bus.start = 1'b0;
    check("zl_start_in_done_ignored", {31'd0, bus.busy}, 32'd0);
    check("zl_done_once", {31'd0, bus.done}, 32'd0);
    check("zl_ram_en2", {31'd0, bus.ram_en}, 32'd0);

    // Backpressure over 64 beats
    start_burst(11'h3C0, 12'd64);
    run_burst(11'h3C0, 64, 1, -1, lc);

    // Start while busy is ignored
    start_burst(11'h200, 12'd6);
    run_burst(11'h200, 6, 1, 2, lc);
    tick();
    check("busy_start_no_rerun", {31'd0, bus.busy}, 32'd0);
    check("busy_start_no_valid", {31'd0, bus.m_valid}, 32'd0);

    // Reset mid-burst after three accepted beats
    start_burst(11'h040, 12'd10);
    bus.m_ready = 1'b1;
    tick();
    tick();
    tick();
    check("abort_beat2", {16'd0, bus.m_data}, 32'h0042);
    tick();
    rst_n = 1'b0;
    #1;
    check_zero_outputs("abort");
    tick();
    check_zero_outputs("abort_hold");
    rst_n = 1'b1;

    // First edge after release accepts start; burst also wraps the address
    start_burst(11'h7FE, 12'd4);
    run_burst(11'h7FE, 4, 0, -1, lc);
    check("wrap_last_cyc", lc, 4);

    // Full-size burst
    start_burst(11'h123, 12'd2048);
    run_burst(11'h123, 2048, 0, -1, lc);
    check("full_last_cyc", lc, 2048);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
